// File: rtl/dmem_port_master.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port_master
// Purpose  : Load/store burst initiator for one shared data-memory port.
//            Issues one memory access per cycle, returns load data as a
//            response stream and pulses done when a burst completes.
// Options  : DMEM_PORT_ADDR_CHECK_EN - reject bursts that run past MEM_DEPTH-1
//            and report them with a one-cycle err pulse.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_port_master #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              done,
`ifdef DMEM_PORT_ADDR_CHECK_EN
    output logic              err,
`endif
    output logic [1:0]        mem_control,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0]        C_CTRL_IDLE  = 2'b00;
    localparam logic [1:0]        C_CTRL_READ  = 2'b10;
    localparam logic [1:0]        C_CTRL_WRITE = 2'b11;
    localparam logic [ADDR_W-1:0] C_ADDR_ONE   = 1;
    localparam logic [4:0]        C_CNT_ONE    = 5'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;          // address of the next access to issue
    logic [4:0]          count_q, count_d;        // accesses still to issue
    logic                req_ready_q, req_ready_d;
    logic                wr_ready_q, wr_ready_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_last_q, rd_last_d;
    logic                done_q, done_d;
    logic                wr_pend_q, wr_pend_d;    // last store word is on the bus now
    logic [1:0]          mem_control_q, mem_control_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

`ifdef DMEM_PORT_ADDR_CHECK_EN
    logic                err_q, err_d;
    logic [ADDR_W:0]     w_end_addr;
    logic                w_addr_ok;

    // Extra bit keeps the end-of-burst sum from wrapping before the compare
    assign w_end_addr = {1'b0, req_addr} + {{(ADDR_W-3){1'b0}}, req_len};
    assign w_addr_ok  = (w_end_addr <= (ADDR_W+1)'(MEM_DEPTH - 1));
    assign err        = err_q;
`endif

    // Next-state and registered-output computation
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        count_d       = count_q;
        mem_control_d = C_CTRL_IDLE;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        rd_valid_d    = 1'b0;
        rd_last_d     = 1'b0;
        done_d        = wr_pend_q;
        wr_pend_d     = 1'b0;
`ifdef DMEM_PORT_ADDR_CHECK_EN
        err_d         = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef DMEM_PORT_ADDR_CHECK_EN
                if (req_valid && !w_addr_ok) begin
                    err_d = 1'b1;
                end else
`endif
                if (req_valid) begin
                    if (req_write) begin
                        state_d = ST_WRITE;
                        addr_d  = req_addr;
                        count_d = {1'b0, req_len} + C_CNT_ONE;
                    end else begin
                        // First read goes out on the acceptance edge
                        state_d       = ST_READ;
                        mem_control_d = C_CTRL_READ;
                        mem_addr_d    = req_addr;
                        addr_d        = req_addr + C_ADDR_ONE;
                        count_d       = {1'b0, req_len};
                    end
                end
            end
            ST_READ: begin
                // A read is on the bus this cycle, so its data returns next cycle
                rd_valid_d = 1'b1;
                if (count_q == 5'd0) begin
                    state_d   = ST_DRAIN;
                    rd_last_d = 1'b1;
                    done_d    = 1'b1;
                end else begin
                    mem_control_d = C_CTRL_READ;
                    mem_addr_d    = addr_q;
                    addr_d        = addr_q + C_ADDR_ONE;
                    count_d       = count_q - C_CNT_ONE;
                end
            end
            ST_WRITE: begin
                if (wr_valid) begin
                    mem_control_d = C_CTRL_WRITE;
                    mem_addr_d    = addr_q;
                    mem_wdata_d   = wr_data;
                    addr_d        = addr_q + C_ADDR_ONE;
                    count_d       = count_q - C_CNT_ONE;
                    if (count_q == C_CNT_ONE) begin
                        state_d   = ST_IDLE;
                        wr_pend_d = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        req_ready_d = (state_d == ST_IDLE);
        wr_ready_d  = (state_d == ST_WRITE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            count_q       <= '0;
            req_ready_q   <= 1'b1;
            wr_ready_q    <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_last_q     <= 1'b0;
            done_q        <= 1'b0;
            wr_pend_q     <= 1'b0;
            mem_control_q <= C_CTRL_IDLE;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
`ifdef DMEM_PORT_ADDR_CHECK_EN
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            count_q       <= count_d;
            req_ready_q   <= req_ready_d;
            wr_ready_q    <= wr_ready_d;
            rd_valid_q    <= rd_valid_d;
            rd_last_q     <= rd_last_d;
            done_q        <= done_d;
            wr_pend_q     <= wr_pend_d;
            mem_control_q <= mem_control_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
`ifdef DMEM_PORT_ADDR_CHECK_EN
            err_q         <= err_d;
`endif
        end
    end

    assign req_ready   = req_ready_q;
    assign wr_ready    = wr_ready_q;
    assign rd_valid    = rd_valid_q;
    assign rd_last     = rd_last_q;
    assign done        = done_q;
    assign mem_control = mem_control_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    // Memory output is already registered; rd_valid qualifies it
    assign rd_data     = mem_rdata;

endmodule
`default_nettype wire

// File: doc/dmem_port_master.md
# dmem_port_master

Initiator for one port of the shared data memory. Accepts single or burst load/store requests from a processing core and drives that port's 2-bit control, address and write-data lines. For loads, it captures the memory's registered read data and returns it to the core as a response stream. One instance sits between each core's load/store logic and its data-memory port.

## Interface
Parameters:
- ADDR_W, 16, address width, matching the memory port.
- DATA_W, 16, data width.
- MEM_DEPTH, 256, number of implemented memory words; used only by the address check.

Ports:
- clock  in  1  system clock; all logic updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_write  in  1  1 = store burst, 0 = load burst.
- req_addr  in  ADDR_W  first word address.
- req_len  in  4  burst length minus 1 (0 = 1 word, 15 = 16 words).
- wr_valid  in  1  store data word present.
- wr_ready  out  1  store word accepted this cycle.
- wr_data  in  DATA_W  store data.
- rd_valid  out  1  load data valid; there is no backpressure.
- rd_data  out  DATA_W  load data.
- rd_last  out  1  marks the final word of a load burst.
- done  out  1  one-cycle pulse when the burst completes.
- err  out  1  one-cycle pulse when a request is rejected; exists only with DMEM_PORT_ADDR_CHECK_EN.
- mem_control  out  2  control encoding to memory: 00 idle, 10 read, 11 write. 01 (instruction fetch) is never driven.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, registered by the memory one edge after a read is issued.

## Operation
- The FSM has four states: IDLE, READ, WRITE, DRAIN.
- IDLE → READ or WRITE on req_valid & req_ready. At acceptance, the block latches the address, write flag and remaining count (req_len+1).
- READ issues one read per cycle: mem_control=10, mem_addr = current address. Address increments and count decrements every cycle. When the last read issues, the FSM goes to DRAIN.
- DRAIN lasts exactly one cycle, for the last returning word, then returns to IDLE.
- WRITE holds wr_ready high. On each cycle with wr_valid=1, the block issues mem_control=11 with the current address and mem_wdata=wr_data, then increments the address and decrements the count.
- A WRITE cycle with wr_valid=0 drives mem_control=00 and leaves address and count unchanged.
- After the last word is accepted in WRITE, the FSM goes to IDLE.
- rd_valid is asserted in the cycle after each read issue, with rd_data = mem_rdata. rd_last accompanies the final word.
- done pulses together with rd_last for loads. For stores, done pulses in the cycle after the last write issues.
- Address arithmetic is modulo 2^ADDR_W: 0xFFFF + 1 = 0x0000.
- A new request is not accepted until the FSM is back in IDLE.

## Timing
- All outputs are registered. rd_data is a pass-through of mem_rdata, qualified by the registered rd_valid.
- Reset values: req_ready=1, wr_ready=0, rd_valid=0, rd_last=0, done=0, err=0, mem_control=00, mem_addr=0, mem_wdata=0, FSM=IDLE.
- Load latency: request accepted at edge E0, first read issued during E0–E1, first rd_valid during E1–E2.
- An N-word load finishes with rd_last at cycle N+1 after acceptance. req_ready is high again in the cycle after rd_last.
- A store needs at least N cycles in WRITE; each gap in wr_valid adds one cycle.
- Reset asserted mid-burst: at the next edge all outputs take their reset values. In-flight read data is discarded; no rd_valid follows.
- req_valid with req_ready=0 is ignored; the requester must hold it.

## Configuration
- DMEM_PORT_ADDR_CHECK_EN defined: at acceptance, the block checks req_addr + req_len ≤ MEM_DEPTH−1. If the check fails:
  - err pulses in the cycle after acceptance and the FSM stays in IDLE;
  - mem_control stays 00, no rd_valid is produced and no done pulse occurs;
  - for a rejected store, no wr_ready is ever asserted.
- DMEM_PORT_ADDR_CHECK_EN undefined: no check is made, err is absent, and addresses wrap at 16 bits.

## Test plan
- Store, addr 0x0010, len 3, wr_data 0xA000..0xA003 with wr_valid continuous → mem_control=11 for four consecutive cycles at addresses 0x10..0x13; done one cycle later.
- Load, addr 0x0010, len 3 → rd_data 0xA000..0xA003 on consecutive cycles; first rd_valid 2 cycles after acceptance; rd_last and done on 0xA003.
- Store, len 1, with one idle wr_valid cycle between words → the gap cycle shows mem_control=00 and mem_addr does not advance; the second word lands at addr+1.
- Reset in the 3rd cycle of a 4-word load → next cycle: mem_control=00, rd_valid=0, req_ready=1; no further rd_valid.
- Without the macro: load at 0xFFFE, len 3 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001. With the macro: load at 0x00FE, len 3 → err pulse, mem_control remains 00.
- Back-to-back single-word loads (len 0) → req_ready low for 2 cycles after each acceptance, then high.
